fu_div_seq: RTL



---
 rtl/fu_div_pkg.sv | 21 ++
 rtl/div_step.sv | 38 +++
 rtl/fu_div_seq.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/fu_div_pkg.sv
// Shared types and constants for the sequential divider functional unit.
package fu_div_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StCalc = 2'd1,
    StFix  = 2'd2,
    StDone = 2'd3
  } div_state_e;

  localparam int unsigned MaxWidth = 64;

  // Quotient reported on divide-by-zero; sliced down to the unit's width.
  localparam logic [MaxWidth-1:0] DBZ_QUOT = '1;

  // Legal configurations: whole quotient bits per cycle and a width the constants cover.
  function automatic bit div_cfg_ok(input int unsigned width, input int unsigned steps);
    return (width >= 4) && (width <= MaxWidth) && (steps != 0) && ((width % steps) == 0);
  endfunction

endpackage

// File: rtl/div_step.sv
// Combinational block of STEPS restoring shift-subtract iterations, MSB first.
module div_step #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned STEPS = 1
) (
  input  logic [WIDTH:0]   prem_i,
  input  logic [WIDTH-1:0] dvd_i,
  input  logic [WIDTH-1:0] dsr_i,
  output logic [WIDTH:0]   prem_o,
  output logic [WIDTH-1:0] dvd_o,
  output logic [STEPS-1:0] quot_o
);

  // Unrolled iterations: shift in the next dividend bit, subtract when the divisor fits.
  always_comb begin
    logic [WIDTH:0]   r;
    logic [WIDTH:0]   t;
    logic [WIDTH-1:0] d;
    r      = prem_i;
    d      = dvd_i;
    t      = '0;
    quot_o = '0;
    for (int unsigned i = 0; i < STEPS; i++) begin
      t      = (r << 1) | {{WIDTH{1'b0}}, d[WIDTH-1]};
      d      = d << 1;
      quot_o = quot_o << 1;
      if (t >= {1'b0, dsr_i}) begin
        r         = t - {1'b0, dsr_i};
        quot_o[0] = 1'b1;
      end else begin
        r = t;
      end
    end
    prem_o = r;
    dvd_o  = d;
  end

endmodule

// File: rtl/fu_div_seq.sv
// Multi-cycle restoring integer divider with signed/unsigned mode, remainder and flush.
module fu_div_seq
  import fu_div_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned STEPS = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             EN,
  input  logic             flush,
  input  logic             sign,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] res,
  output logic [WIDTH-1:0] rem,
  output logic             finish,
  output logic             busy,
  output logic             dbz
);

  localparam int unsigned ITER = WIDTH / STEPS;
  localparam int unsigned CntW = $clog2(ITER + 1);

  if (!div_cfg_ok(WIDTH, STEPS)) begin : g_cfg_err
    $error("fu_div_seq: WIDTH must be >= 4, <= 64 and a multiple of STEPS");
  end

  div_state_e       state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH:0]   prem_q, prem_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dsr_q, dsr_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH:0]   step_prem;
  logic [WIDTH-1:0] step_dvd;
  logic [STEPS-1:0] step_quot;

  logic             accept;
  logic             a_neg, b_neg;

  assign accept = (state_q == StIdle) && EN && !flush;
  assign a_neg  = sign && A[WIDTH-1];
  assign b_neg  = sign && B[WIDTH-1];

  div_step #(
    .WIDTH (WIDTH),
    .STEPS (STEPS)
  ) u_step (
    .prem_i (prem_q),
    .dvd_i  (dvd_q),
    .dsr_i  (dsr_q),
    .prem_o (step_prem),
    .dvd_o  (step_dvd),
    .quot_o (step_quot)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; flush returns to idle from any state.
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: if (EN) state_d = (B == '0) ? StDone : StCalc;
        StCalc: if (cnt_q == CntW'(1)) state_d = StFix;
        StFix:  state_d = StDone;
        StDone: state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  // Status outputs decoded from the registered state only.
  always_comb begin
    busy   = (state_q != StIdle);
    finish = (state_q == StDone);
  end

  // Datapath next-state: operand capture, iteration and sign fix-up.
  always_comb begin
    cnt_d  = cnt_q;
    prem_d = prem_q;
    dvd_d  = dvd_q;
    dsr_d  = dsr_q;
    quo_d  = quo_q;
    qneg_d = qneg_q;
    rneg_d = rneg_q;
    res_d  = res_q;
    rem_d  = rem_q;
    dbz_d  = dbz_q;
    if (accept) begin
      if (B == '0) begin
        res_d = DBZ_QUOT[WIDTH-1:0];
        rem_d = A;
        dbz_d = 1'b1;
      end else begin
        prem_d = '0;
        dvd_d  = a_neg ? -A : A;
        dsr_d  = b_neg ? -B : B;
        quo_d  = '0;
        qneg_d = a_neg ^ b_neg;
        rneg_d = a_neg;
        cnt_d  = CntW'(ITER);
        dbz_d  = 1'b0;
      end
    end else if (!flush && state_q == StCalc) begin
      prem_d = step_prem;
      dvd_d  = step_dvd;
      quo_d  = (quo_q << STEPS) | WIDTH'(step_quot);
      cnt_d  = cnt_q - CntW'(1);
    end else if (!flush && state_q == StFix) begin
      // MIN / -1 wraps back to MIN through the negation, which is the wanted result.
      res_d = qneg_q ? -quo_q : quo_q;
      rem_d = rneg_q ? -prem_q[WIDTH-1:0] : prem_q[WIDTH-1:0];
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      prem_q <= '0;
      dvd_q  <= '0;
      dsr_q  <= '0;
      quo_q  <= '0;
      qneg_q <= 1'b0;
      rneg_q <= 1'b0;
      res_q  <= '0;
      rem_q  <= '0;
      dbz_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      prem_q <= prem_d;
      dvd_q  <= dvd_d;
      dsr_q  <= dsr_d;
      quo_q  <= quo_d;
      qneg_q <= qneg_d;
      rneg_q <= rneg_d;
      res_q  <= res_d;
      rem_q  <= rem_d;
      dbz_q  <= dbz_d;
    end
  end

  assign res = res_q;
  assign rem = rem_q;
  assign dbz = dbz_q;

endmodule
